target_encoder: RTL and testbench

Converts a class label (spoken-word index 0..19) into the 20-element target vector for the 20 network output neurons, one element per cycle on a valid/ready stream. It is the reverse of the output checker: the checker reduces 20 neuron outputs to a 20-bit one-hot class code, and this block expands a class index back into target values. It sits between the label source (host/switch interface) and the training/error-calculation datapath. It also exports the label's one-hot code in the checker's bit format, so the two can be compared directly.

---
 rtl/target_encoder_pkg.sv | 17 +
 rtl/target_encoder_onehot.sv | 20 ++
 rtl/target_encoder.sv | 111 +++++++++++
 tb/tb_target_encoder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/target_encoder_pkg.sv
// Shared class-count, Q16.16 constants and FSM encoding
// for the target encoder and the output checker.
package target_encoder_pkg;

  localparam int NUM_OUT_DEF    = 20;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int IDX_W          = 5;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/target_encoder_onehot.sv
// Class index to one-hot code, bit k set for class k.
// Out-of-range indices give an all-zero code.
module idx_to_onehot
  import target_encoder_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_OUT-1:0] onehot
);

  // one comparator per class bit
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      onehot[k] = (idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/target_encoder.sv
// Expands a class label into a NUM_OUT-element target
// vector, one element per valid/ready handshake.
module target_encoder
  import target_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_OUT    = NUM_OUT_DEF,
  parameter logic [DATA_WIDTH-1:0] TARGET_HI = ONE,
  parameter logic [DATA_WIDTH-1:0] TARGET_LO = ZERO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  label_valid,
  output logic                  label_ready,
  input  logic [IDX_W-1:0]      label_idx,
  output logic                  tgt_valid,
  input  logic                  tgt_ready,
  output logic [DATA_WIDTH-1:0] tgt_data,
  output logic [IDX_W-1:0]      tgt_idx,
  output logic                  tgt_last,
  output logic [NUM_OUT-1:0]    label_onehot,
  output logic                  label_err,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   lbl;
  logic [IDX_W-1:0]   nxt;
  logic [NUM_OUT-1:0] oh;
  logic               acc;
  logic               legal;
  logic               hs;

  idx_to_onehot #(
    .NUM_OUT (NUM_OUT)
  ) u_oh (
    .idx    (label_idx),
    .onehot (oh)
  );

  assign acc   = label_valid && label_ready;
  assign legal = (label_idx <= LAST);
  assign hs    = tgt_valid && tgt_ready;
  assign nxt   = tgt_idx + IDX_W'(1);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: legal label starts a vector, last handshake ends it
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (acc && legal)     state_nxt = EMIT;
      EMIT: if (hs && tgt_last)   state_nxt = IDLE;
    endcase
  end

  // ready is decoded from state and held low while in reset
  always_comb begin
    label_ready = !rst && (state == IDLE);
  end

  // registered stream outputs; tgt_idx doubles as element counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lbl          <= '0;
      tgt_valid    <= 1'b0;
      tgt_data     <= '0;
      tgt_idx      <= '0;
      tgt_last     <= 1'b0;
      label_onehot <= '0;
      label_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      label_err <= 1'b0;
      if (acc) begin
        if (legal) begin
          lbl          <= label_idx;
          label_onehot <= oh;
          tgt_valid    <= 1'b1;
          busy         <= 1'b1;
          tgt_idx      <= '0;
          tgt_last     <= (LAST == '0);
          tgt_data     <= (label_idx == '0) ? TARGET_HI
                                            : TARGET_LO;
        end else begin
          label_err <= 1'b1;
        end
      end else if (state == EMIT && hs) begin
        if (tgt_last) begin
          tgt_valid <= 1'b0;
          busy      <= 1'b0;
          tgt_idx   <= '0;
          tgt_last  <= 1'b0;
          tgt_data  <= '0;
        end else begin
          tgt_idx  <= nxt;
          tgt_last <= (nxt == LAST);
          tgt_data <= (nxt == lbl) ? TARGET_HI : TARGET_LO;
        end
      end
    end
  end

endmodule

// File: tb/tb_target_encoder.sv
// Directed bench for target_encoder: vector contents,
// back-to-back labels, backpressure, bad label, reset abort.
module tb_target_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        label_valid;
  logic        label_ready;
  logic [4:0]  label_idx;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [31:0] tgt_data;
  logic [4:0]  tgt_idx;
  logic        tgt_last;
  logic [19:0] label_onehot;
  logic        label_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] HI = 32'h0001_0000;

  target_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .label_valid  (label_valid),
    .label_ready  (label_ready),
    .label_idx    (label_idx),
    .tgt_valid    (tgt_valid),
    .tgt_ready    (tgt_ready),
    .tgt_data     (tgt_data),
    .tgt_idx      (tgt_idx),
    .tgt_last     (tgt_last),
    .label_onehot (label_onehot),
    .label_err    (label_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // checks a full vector with tgt_ready high, starting
  // just after the accepting edge
  task automatic run_vec(input int lbl);
    logic [31:0] eoh;
    eoh = 32'd1 << lbl;
    for (int i = 0; i < 20; i++) begin
      chk("vec_valid", {31'd0, tgt_valid}, 32'd1);
      chk("vec_idx", {27'd0, tgt_idx}, i);
      chk("vec_data", tgt_data, (i == lbl) ? HI : 32'd0);
      chk("vec_last", {31'd0, tgt_last}, (i == 19) ? 1 : 0);
      chk("vec_onehot", {12'd0, label_onehot}, eoh);
      chk("vec_lready", {31'd0, label_ready}, 32'd0);
      tick();
    end
    chk("end_valid", {31'd0, tgt_valid}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_lready", {31'd0, label_ready}, 32'd1);
  endtask

  initial begin
    int hs;
    logic [31:0] held;
    rst         = 1'b1;
    label_valid = 1'b0;
    label_idx   = '0;
    tgt_ready   = 1'b0;
    tick();
    tick();
    chk("rst_lready", {31'd0, label_ready}, 32'd0);
    chk("rst_valid", {31'd0, tgt_valid}, 32'd0);
    chk("rst_data", tgt_data, 32'd0);
    chk("rst_idx", {27'd0, tgt_idx}, 32'd0);
    chk("rst_last", {31'd0, tgt_last}, 32'd0);
    chk("rst_onehot", {12'd0, label_onehot}, 32'd0);
    chk("rst_err", {31'd0, label_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_lready", {31'd0, label_ready}, 32'd1);

    // label 7, no backpressure
    tgt_ready   = 1'b1;
    label_valid = 1'b1;
    label_idx   = 5'd7;
    tick();
    label_valid = 1'b0;
    chk("l7_busy", {31'd0, busy}, 32'd1);
    chk("l7_onehot", {12'd0, label_onehot}, 32'h0_0080);
    run_vec(7);

    // label 0 then 19 held during EMIT, accepted back-to-back
    label_valid = 1'b1;
    label_idx   = 5'd0;
    tick();
    label_idx = 5'd19;
    run_vec(0);
    tick();
    label_valid = 1'b0;
    chk("b2b_onehot", {12'd0, label_onehot}, 32'h8_0000);
    run_vec(19);

    // label 3 with tgt_ready pattern 1,0,0,1,0,0,...
    label_valid = 1'b1;
    label_idx   = 5'd3;
    tick();
    label_valid = 1'b0;
    hs = 0;
    held = 32'hdead_beef;
    for (int c = 0; c < 200 && hs < 20; c++) begin
      chk("bp_valid", {31'd0, tgt_valid}, 32'd1);
      chk("bp_idx", {27'd0, tgt_idx}, hs);
      chk("bp_data", tgt_data, (hs == 3) ? HI : 32'd0);
      chk("bp_last", {31'd0, tgt_last}, (hs == 19) ? 1 : 0);
      tgt_ready = (c % 3 == 0);
      if (tgt_valid && tgt_ready) hs++;
      tick();
    end
    chk("bp_count", hs, 32'd20);
    tgt_ready = 1'b1;
    tick();
    chk("bp_no_extra", {31'd0, tgt_valid}, 32'd0);
    chk("bp_onehot", {12'd0, label_onehot}, 32'h0_0008);

    // out-of-range label 25
    label_valid = 1'b1;
    label_idx   = 5'd25;
    tick();
    label_valid = 1'b0;
    chk("bad_err", {31'd0, label_err}, 32'd1);
    chk("bad_valid", {31'd0, tgt_valid}, 32'd0);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_lready", {31'd0, label_ready}, 32'd1);
    chk("bad_onehot", {12'd0, label_onehot}, 32'h0_0008);
    tick();
    chk("bad_err_drop", {31'd0, label_err}, 32'd0);
    chk("bad_valid2", {31'd0, tgt_valid}, 32'd0);

    // label 12 aborted by reset at idx 5
    label_valid = 1'b1;
    label_idx   = 5'd12;
    tick();
    label_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_idx", {27'd0, tgt_idx}, 32'd5);
    chk("abort_onehot", {12'd0, label_onehot}, 32'h0_1000);
    rst = 1'b1;
    #1;
    chk("abort_lready", {31'd0, label_ready}, 32'd0);
    tick();
    rst = 1'b0;
    chk("abort_valid", {31'd0, tgt_valid}, 32'd0);
    chk("abort_onehot0", {12'd0, label_onehot}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_idx0", {27'd0, tgt_idx}, 32'd0);
    tick();
    chk("abort_quiet", {31'd0, tgt_valid}, 32'd0);

    // new label 2 after reset
    label_valid = 1'b1;
    label_idx   = 5'd2;
    tick();
    label_valid = 1'b0;
    run_vec(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
